hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 548 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, flush and operand-forward control for the 5-stage pipe.
// Optional feature: define HAZARD_FORWARD_EN to enable EX operand forwarding.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regw,
  input  logic        ex_memr,
  input  logic [4:0]  mem_rd,
  input  logic        mem_regw,
  input  logic [4:0]  wb_rd,
  input  logic        wb_regw,
  input  logic        br_taken,
  input  logic        mdu_start,
  input  logic        mdu_div,
  input  logic        id_hilo,
  output logic        pc_wr,
  output logic        if_id_wr,
  output logic        id_ex_wr,
  output logic        ex_mem_wr,
  output logic        mem_wb_wr,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  state,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_STALL = 2'b01,
    S_FLUSH = 2'b10,
    S_MDU   = 2'b11
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_stall_cnt;

  logic        w_ex_hit;
  logic        w_hz;
  logic        w_busy;
  logic        w_stall;
  logic [1:0]  w_fa;
  logic [1:0]  w_fb;
  logic [3:0]  w_cnt_nxt;

  // Register 0 is hard-wired zero, so it never matches.
  function automatic logic f_hit(
    input logic [4:0] d,
    input logic       w,
    input logic [4:0] s,
    input logic       u
  );
    return w && (d != 5'd0) && (d == s) && u;
  endfunction

  assign w_ex_hit = f_hit(ex_rd, ex_regw, id_rs, id_use_rs)
                  | f_hit(ex_rd, ex_regw, id_rt, id_use_rt);

`ifdef HAZARD_FORWARD_EN
  // EX/MEM is the younger result, so it wins over MEM/WB.
  function automatic logic [1:0] f_fwd(
    input logic [4:0] s,
    input logic       mw,
    input logic [4:0] md,
    input logic       ww,
    input logic [4:0] wd
  );
    logic [1:0] v;
    if (f_hit(md, mw, s, 1'b1))
      v = 2'b10;
    else if (f_hit(wd, ww, s, 1'b1))
      v = 2'b01;
    else
      v = 2'b00;
    return v;
  endfunction

  assign w_hz = ex_memr & w_ex_hit;
  assign w_fa = f_fwd(ex_rs, mem_regw, mem_rd, wb_regw, wb_rd);
  assign w_fb = f_fwd(ex_rt, mem_regw, mem_rd, wb_regw, wb_rd);
`else
  logic w_mem_hit;
  logic w_wb_hit;
  logic w_unused;

  // Without bypass every in-flight producer blocks the reader.
  assign w_mem_hit = f_hit(mem_rd, mem_regw, id_rs, id_use_rs)
                   | f_hit(mem_rd, mem_regw, id_rt, id_use_rt);
  assign w_wb_hit  = f_hit(wb_rd, wb_regw, id_rs, id_use_rs)
                   | f_hit(wb_rd, wb_regw, id_rt, id_use_rt);
  assign w_hz      = w_ex_hit | w_mem_hit | w_wb_hit;
  assign w_fa      = 2'b00;
  assign w_fb      = 2'b00;
  assign w_unused  = ^{ex_rs, ex_rt, ex_memr};
`endif

  assign w_busy  = (r_cnt != 4'd0);
  assign w_stall = ~br_taken & (w_hz | (w_busy & id_hilo));

  // Busy counter: a redirect cancels a start but not a running op.
  always_comb begin
    w_cnt_nxt = 4'd0;
    if (mdu_start && !br_taken)
      w_cnt_nxt = mdu_div ? 4'd15 : 4'd3;
    else if (w_busy)
      w_cnt_nxt = r_cnt - 4'd1;
  end

  // Per-cycle enables/flushes; redirect beats any stall.
  always_comb begin
    pc_wr        = 1'b1;
    if_id_wr     = 1'b1;
    id_ex_wr     = 1'b1;
    ex_mem_wr    = 1'b1;
    mem_wb_wr    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    fwd_a        = 2'b00;
    fwd_b        = 2'b00;
    if (rst) begin
      fwd_a = w_fa;
      fwd_b = w_fb;
      if (br_taken) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (w_stall) begin
        pc_wr       = 1'b0;
        if_id_wr    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // FSM: records what the pipe did this cycle, plus MDU busy time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_RUN;
      r_cnt       <= 4'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (br_taken)
        r_state <= S_FLUSH;
      else if (mdu_start)
        r_state <= S_MDU;
      else if (w_hz)
        r_state <= S_STALL;
      else if (w_cnt_nxt != 4'd0)
        r_state <= S_MDU;
      else
        r_state <= S_RUN;
    end
  end

  assign state        = r_state;
  assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl.
// Expectations follow HAZARD_FORWARD_EN when it is defined.
module tb_hazard_ctrl;

  localparam logic [1:0] S_RUN   = 2'b00;
  localparam logic [1:0] S_STALL = 2'b01;
  localparam logic [1:0] S_FLUSH = 2'b10;
  localparam logic [1:0] S_MDU   = 2'b11;

  localparam logic [11:0] C_RUN   = 12'b11111_000_0000;
  localparam logic [11:0] C_STALL = 12'b00111_010_0000;
  localparam logic [11:0] C_FLUSH = 12'b11111_111_0000;

  typedef struct {
    string       nm;
    logic [11:0] ctl;
    logic [1:0]  st;
    logic [31:0] sc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt;
  logic        id_use_rs, id_use_rt;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_regw, ex_memr;
  logic [4:0]  mem_rd;
  logic        mem_regw;
  logic [4:0]  wb_rd;
  logic        wb_regw;
  logic        br_taken, mdu_start, mdu_div, id_hilo;
  logic        pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr;
  logic        if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0]  fwd_a, fwd_b, state;
  logic [31:0] stall_cycles;
  logic [11:0] w_ctl;

  exp_t        q[$];
  logic [31:0] exp_sc;
  int          n_chk;
  int          n_fail;

  hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_rd        (ex_rd),
    .ex_regw      (ex_regw),
    .ex_memr      (ex_memr),
    .mem_rd       (mem_rd),
    .mem_regw     (mem_regw),
    .wb_rd        (wb_rd),
    .wb_regw      (wb_regw),
    .br_taken     (br_taken),
    .mdu_start    (mdu_start),
    .mdu_div      (mdu_div),
    .id_hilo      (id_hilo),
    .pc_wr        (pc_wr),
    .if_id_wr     (if_id_wr),
    .id_ex_wr     (id_ex_wr),
    .ex_mem_wr    (ex_mem_wr),
    .mem_wb_wr    (mem_wb_wr),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .state        (state),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  assign w_ctl = {pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr,
                  if_id_flush, id_ex_flush, ex_mem_flush, fwd_a, fwd_b};

  function automatic logic [11:0] run_f(input logic [1:0] fa, input logic [1:0] fb);
    return {C_RUN[11:4], fa, fb};
  endfunction

  task automatic neutral();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_regw = 0; ex_memr = 0;
    mem_rd = 0; mem_regw = 0; wb_rd = 0; wb_regw = 0;
    br_taken = 0; mdu_start = 0; mdu_div = 0; id_hilo = 0;
  endtask

  task automatic push(input string nm, input logic [11:0] c, input logic [1:0] s);
    exp_t e;
    if (rst && !c[11] && exp_sc != 32'hFFFF_FFFF)
      exp_sc = exp_sc + 1;
    e.nm = nm;
    e.ctl = c;
    e.st = s;
    e.sc = exp_sc;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    neutral();
    rst = 1'b0;
    exp_sc = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      neutral();
      rst = (i == 2);
      if (i < 2) begin
        ex_memr = 1; ex_regw = 1; ex_rd = 2;
        id_rs = 2; id_use_rs = 1;
        br_taken = 1; mdu_start = 1; mdu_div = 1; id_hilo = 1;
        ex_rs = 4; mem_rd = 4; mem_regw = 1;
        push("rst_hold", C_RUN, S_RUN);
      end else begin
        push("rst_first", C_RUN, S_RUN);
      end
      #1;
      e = q.pop_front();
      n_chk++;
      if (w_ctl !== e.ctl) begin
        n_fail++;
        $display("FAIL %s ctl got %b want %b", e.nm, w_ctl, e.ctl);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL %s state got %b want %b", e.nm, state, e.st);
      end
      n_chk++;
      if (stall_cycles !== e.sc) begin
        n_fail++;
        $display("FAIL %s stalls got %0d want %0d", e.nm, stall_cycles, e.sc);
      end
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      neutral();
      id_rs = 2; id_rt = 1; id_use_rs = 1; id_use_rt = 1;
`ifdef HAZARD_FORWARD_EN
      case (i)
        0: begin
          ex_memr = 1; ex_regw = 1; ex_rd = 2; ex_rs = 5; ex_rt = 6;
          push("lu_stall", C_STALL, S_STALL);
        end
        1: begin
          mem_rd = 2; mem_regw = 1;
          push("lu_bubble", C_RUN, S_RUN);
        end
        2: begin
          ex_rs = 2; ex_rt = 1; ex_rd = 3; ex_regw = 1;
          wb_rd = 2; wb_regw = 1;
          id_rs = 4; id_rt = 5;
          push("lu_fwd_wb", run_f(2'b01, 2'b00), S_RUN);
        end
        3: begin
          ex_memr = 1; ex_regw = 1; ex_rd = 0; id_rs = 0; id_rt = 0;
          push("lu_r0", C_RUN, S_RUN);
        end
        default: begin
          ex_memr = 1; ex_regw = 1; ex_rd = 7;
          id_rs = 7; id_use_rs = 0; id_rt = 8;
          push("lu_nouse", C_RUN, S_RUN);
        end
      endcase
`else
      case (i)
        0: begin
          ex_memr = 1; ex_regw = 1; ex_rd = 2; ex_rs = 5; ex_rt = 6;
          push("raw_ex", C_STALL, S_STALL);
        end
        1: begin
          mem_rd = 2; mem_regw = 1;
          push("raw_mem", C_STALL, S_STALL);
        end
        2: begin
          wb_rd = 2; wb_regw = 1;
          push("raw_wb", C_STALL, S_STALL);
        end
        3: begin
          ex_rs = 2; ex_rt = 1; ex_rd = 3; ex_regw = 1;
          mem_rd = 2; mem_regw = 1; wb_rd = 1; wb_regw = 1;
          id_rs = 4; id_rt = 5;
          push("raw_fwd0", C_RUN, S_RUN);
        end
        4: begin
          ex_memr = 1; ex_regw = 1; ex_rd = 0; id_rs = 0; id_rt = 0;
          push("raw_r0", C_RUN, S_RUN);
        end
        default: begin
          ex_memr = 1; ex_regw = 1; ex_rd = 7;
          id_rs = 7; id_use_rs = 0; id_rt = 8;
          push("raw_nouse", C_RUN, S_RUN);
        end
      endcase
`endif
      #1;
      e = q.pop_front();
      n_chk++;
      if (w_ctl !== e.ctl) begin
        n_fail++;
        $display("FAIL %s ctl got %b want %b", e.nm, w_ctl, e.ctl);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL %s state got %b want %b", e.nm, state, e.st);
      end
      n_chk++;
      if (stall_cycles !== e.sc) begin
        n_fail++;
        $display("FAIL %s stalls got %0d want %0d", e.nm, stall_cycles, e.sc);
      end
    end
  endtask

  task automatic test_alu_fwd();
    exp_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      neutral();
      id_rs = 6; id_rt = 7; id_use_rs = 1; id_use_rt = 1;
`ifdef HAZARD_FORWARD_EN
      case (i)
        0: begin
          ex_regw = 1; ex_rd = 2; id_rs = 2; id_rt = 2;
          push("alu_nostall", C_RUN, S_RUN);
        end
        1: begin
          ex_rs = 2; ex_rt = 2; ex_rd = 4; ex_regw = 1;
          mem_rd = 2; mem_regw = 1; wb_rd = 2; wb_regw = 1;
          push("alu_fwd_mem", run_f(2'b10, 2'b10), S_RUN);
        end
        2: begin
          ex_rs = 3; ex_rt = 0;
          mem_rd = 0; mem_regw = 1; wb_rd = 3; wb_regw = 1;
          push("alu_fwd_r0", run_f(2'b01, 2'b00), S_RUN);
        end
        3: begin
          ex_rs = 9; ex_rt = 9;
          mem_rd = 9; mem_regw = 0; wb_rd = 9; wb_regw = 1;
          push("alu_fwd_wbonly", run_f(2'b01, 2'b01), S_RUN);
        end
        default: begin
          ex_rs = 0; ex_rt = 0;
          mem_rd = 0; mem_regw = 1; wb_rd = 0; wb_regw = 1;
          push("alu_fwd_none", C_RUN, S_RUN);
        end
      endcase
`else
      case (i)
        0: begin
          ex_regw = 1; ex_rd = 2; id_rs = 2; id_rt = 2;
          push("alu_raw_ex", C_STALL, S_STALL);
        end
        1: begin
          mem_rd = 2; mem_regw = 1; id_rs = 2; id_rt = 2;
          push("alu_raw_mem", C_STALL, S_STALL);
        end
        2: begin
          wb_rd = 2; wb_regw = 1; id_rs = 2; id_rt = 2;
          push("alu_raw_wb", C_STALL, S_STALL);
        end
        3: begin
          ex_rs = 2; ex_rt = 2; ex_rd = 4; ex_regw = 1;
          mem_rd = 2; mem_regw = 1;
          push("alu_sub_ex", C_RUN, S_RUN);
        end
        default: begin
          ex_regw = 1; ex_rd = 0; mem_regw = 1; mem_rd = 0;
          wb_regw = 1; wb_rd = 0; id_rs = 0; id_rt = 0;
          push("alu_r0", C_RUN, S_RUN);
        end
      endcase
`endif
      #1;
      e = q.pop_front();
      n_chk++;
      if (w_ctl !== e.ctl) begin
        n_fail++;
        $display("FAIL %s ctl got %b want %b", e.nm, w_ctl, e.ctl);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL %s state got %b want %b", e.nm, state, e.st);
      end
      n_chk++;
      if (stall_cycles !== e.sc) begin
        n_fail++;
        $display("FAIL %s stalls got %0d want %0d", e.nm, stall_cycles, e.sc);
      end
    end
  endtask

  task automatic test_branch();
    exp_t e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      neutral();
      case (i)
        0: begin
          ex_memr = 1; ex_regw = 1; ex_rd = 2;
          id_rs = 2; id_use_rs = 1; br_taken = 1;
          push("br_vs_lu", C_FLUSH, S_FLUSH);
        end
        1: push("br_after", C_RUN, S_RUN);
        2: begin
          br_taken = 1; mdu_start = 1; mdu_div = 1;
          push("br_vs_mdu", C_FLUSH, S_FLUSH);
        end
        default: begin
          id_hilo = 1;
          push("br_mdu_drop", C_RUN, S_RUN);
        end
      endcase
      #1;
      e = q.pop_front();
      n_chk++;
      if (w_ctl !== e.ctl) begin
        n_fail++;
        $display("FAIL %s ctl got %b want %b", e.nm, w_ctl, e.ctl);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL %s state got %b want %b", e.nm, state, e.st);
      end
      n_chk++;
      if (stall_cycles !== e.sc) begin
        n_fail++;
        $display("FAIL %s stalls got %0d want %0d", e.nm, stall_cycles, e.sc);
      end
    end
  endtask

  task automatic test_div();
    exp_t e;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      neutral();
      if (i == 0) begin
        mdu_start = 1; mdu_div = 1;
        push("div_start", C_RUN, S_MDU);
      end else if (i <= 15) begin
        id_hilo = 1;
        push($sformatf("div_wait%0d", i), C_STALL, (i == 15) ? S_RUN : S_MDU);
      end else begin
        id_hilo = 1;
        push("div_release", C_RUN, S_RUN);
      end
      #1;
      e = q.pop_front();
      n_chk++;
      if (w_ctl !== e.ctl) begin
        n_fail++;
        $display("FAIL %s ctl got %b want %b", e.nm, w_ctl, e.ctl);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL %s state got %b want %b", e.nm, state, e.st);
      end
      n_chk++;
      if (stall_cycles !== e.sc) begin
        n_fail++;
        $display("FAIL %s stalls got %0d want %0d", e.nm, stall_cycles, e.sc);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      neutral();
      case (i)
        0: begin
          mdu_start = 1;
          push("mul_start", C_RUN, S_MDU);
        end
        1: begin
          id_rs = 3; id_use_rs = 1;
          push("mul_add_free", C_RUN, S_MDU);
        end
        2: begin
          id_hilo = 1;
          push("mul_wait_a", C_STALL, S_MDU);
        end
        3: begin
          id_hilo = 1;
          push("mul_wait_b", C_STALL, S_RUN);
        end
        4: begin
          id_hilo = 1;
          push("mul_release", C_RUN, S_RUN);
        end
        5: begin
          mdu_start = 1;
          push("mul2_start", C_RUN, S_MDU);
        end
        6: begin
          br_taken = 1; id_hilo = 1;
          push("mul2_br", C_FLUSH, S_FLUSH);
        end
        7: begin
          id_hilo = 1;
          push("mul2_back", C_STALL, S_MDU);
        end
        8: begin
          id_hilo = 1;
          push("mul2_last", C_STALL, S_RUN);
        end
        default: begin
          id_hilo = 1;
          push("mul2_release", C_RUN, S_RUN);
        end
      endcase
      #1;
      e = q.pop_front();
      n_chk++;
      if (w_ctl !== e.ctl) begin
        n_fail++;
        $display("FAIL %s ctl got %b want %b", e.nm, w_ctl, e.ctl);
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL %s state got %b want %b", e.nm, state, e.st);
      end
      n_chk++;
      if (stall_cycles !== e.sc) begin
        n_fail++;
        $display("FAIL %s stalls got %0d want %0d", e.nm, stall_cycles, e.sc);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      neutral();
      rst = 1'b1;
      if (i == 0) begin
        mdu_start = 1; mdu_div = 1;
        push("rm_start", C_RUN, S_MDU);
      end else if (i <= 5) begin
        id_hilo = 1;
        push($sformatf("rm_wait%0d", i), C_STALL, S_MDU);
      end else begin
        id_hilo = 1;
        push($sformatf("rm_after%0d", i), C_RUN, S_RUN);
      end
      #1;
      e = q.pop_front();
      n_chk++;
      if (w_ctl !== e.ctl) begin
        n_fail++;
        $display("FAIL %s ctl got %b want %b", e.nm, w_ctl, e.ctl);
      end
      if (i == 5) begin
        rst = 1'b0;
        exp_sc = 0;
        #1;
        n_chk++;
        if (state !== S_RUN) begin
          n_fail++;
          $display("FAIL rm_async_state got %b want %b", state, S_RUN);
        end
        n_chk++;
        if (stall_cycles !== exp_sc) begin
          n_fail++;
          $display("FAIL rm_async_stalls got %0d want %0d", stall_cycles, exp_sc);
        end
        n_chk++;
        if (w_ctl !== C_RUN) begin
          n_fail++;
          $display("FAIL rm_async_ctl got %b want %b", w_ctl, C_RUN);
        end
        e.st = S_RUN;
        e.sc = exp_sc;
      end
      @(posedge clk);
      #1;
      n_chk++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL %s state got %b want %b", e.nm, state, e.st);
      end
      n_chk++;
      if (stall_cycles !== e.sc) begin
        n_fail++;
        $display("FAIL %s stalls got %0d want %0d", e.nm, stall_cycles, e.sc);
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    exp_sc = 0;
    rst = 1'b0;
    neutral();
    test_reset();
    test_load_use();
    test_alu_fwd();
    test_branch();
    test_div();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
